// File: rtl/control_pkg.sv
// Shared control-path types for the datapath ALU: opcodes, status flags and
// the sequencing state of the iterative multiply/divide ALU.
package control;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_SHL = 4'd2,
    OP_ROL = 4'd3,
    OP_SHR = 4'd4,
    OP_ROR = 4'd5,
    OP_AND = 4'd6,
    OP_OR  = 4'd7,
    OP_XOR = 4'd8,
    OP_NOT = 4'd9,
    OP_MUL = 4'd10,
    OP_DIV = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic negative;
    logic overflow;
    logic remainder;
    logic div_zero;
  } alu_flags_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alu_state_e;

  // Divide by zero completes in one cycle, so it never enters the iterative path.
  function automatic logic is_iterative(input alu_op_e op, input logic b_is_zero);
    return (op == OP_MUL) || ((op == OP_DIV) && !b_is_zero);
  endfunction

endpackage

// File: rtl/alu_seq_muldiv_iter.sv
// Iterative datapath for MUL (shift-add) and DIV (restoring): one iteration per
// step, WIDTH steps per operation. res_* present the result of the current step.
module alu_muldiv_iter
  import control::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             is_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             step,
  output logic             last,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // hi_r: partial product high half / partial remainder
  // lo_r: multiplier being shifted out / dividend becoming quotient
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] b_r;
  logic [CNT_W-1:0] count_r;
  logic             is_div_r;

  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   diff_s;
  logic             fits_s;
  logic [WIDTH-1:0] hi_nxt_s;
  logic [WIDTH-1:0] lo_nxt_s;

  // One iteration of either algorithm, computed from the partial registers.
  always_comb begin
    add_s     = {1'b0, hi_r} + {1'b0, b_r};
    shifted_s = {hi_r, lo_r[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, b_r};
    // Bit WIDTH of the difference is set exactly when the divisor does not fit.
    fits_s    = ~diff_s[WIDTH];
    if (is_div_r) begin
      if (fits_s) begin
        hi_nxt_s = diff_s[WIDTH-1:0];
      end else begin
        hi_nxt_s = shifted_s[WIDTH-1:0];
      end
      lo_nxt_s = {lo_r[WIDTH-2:0], fits_s};
    end else if (lo_r[0]) begin
      hi_nxt_s = add_s[WIDTH:1];
      lo_nxt_s = {add_s[0], lo_r[WIDTH-1:1]};
    end else begin
      hi_nxt_s = {1'b0, hi_r[WIDTH-1:1]};
      lo_nxt_s = {hi_r[0], lo_r[WIDTH-1:1]};
    end
  end

  // Partial registers and iteration counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      is_div_r <= 1'b0;
    end else if (load) begin
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= operand_a;
      b_r      <= operand_b;
      count_r  <= CNT_W'(WIDTH);
      is_div_r <= is_div;
    end else if (step && (count_r != {CNT_W{1'b0}})) begin
      hi_r     <= hi_nxt_s;
      lo_r     <= lo_nxt_s;
      count_r  <= count_r - CNT_W'(1);
    end
  end

  assign last   = (count_r == CNT_W'(1));
  assign res_lo = lo_nxt_s;
  assign res_hi = hi_nxt_s;

endmodule

// File: rtl/alu_seq.sv
// Parametrised sequential ALU: single-cycle logic/arithmetic/shift ops plus
// iterative MUL/DIV, with status flags, start/ready/done handshake and bus gating.
module alu_seq
  import control::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             out,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output alu_flags_t       flags,
  output logic             done
);

  localparam int M = WIDTH - 1;

  alu_state_e       state_r;
  alu_state_e       state_nxt_s;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] result_hi_r;
  alu_flags_t       flags_r;
  logic             done_r;
  logic             div_r;

  logic             accept_s;
  logic             iter_s;
  logic             load_s;
  logic             step_s;
  logic             last_s;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] sc_lo_s;
  logic [WIDTH-1:0] sc_hi_s;
  logic             sc_defined_s;
  alu_flags_t       sc_flags_s;
  logic [WIDTH-1:0] it_lo_s;
  logic [WIDTH-1:0] it_hi_s;
  alu_flags_t       it_flags_s;

  assign accept_s = start && (state_r == IDLE);
  assign iter_s   = is_iterative(op, operand_b == {WIDTH{1'b0}});

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clock    (clock),
    .reset    (reset),
    .load     (load_s),
    .is_div   (op == OP_DIV),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .step     (step_s),
    .last     (last_s),
    .res_lo   (it_lo_s),
    .res_hi   (it_hi_s)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and iterative-datapath control.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s && iter_s) begin
          load_s      = 1'b1;
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        step_s = 1'b1;
        if (last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Single-cycle ops; MUL and nonzero DIV never complete through this path.
  always_comb begin
    sum_s        = {(WIDTH+1){1'b0}};
    sc_lo_s      = {WIDTH{1'b0}};
    sc_hi_s      = {WIDTH{1'b0}};
    sc_defined_s = 1'b1;
    sc_flags_s   = 6'b0;
    case (op)
      OP_ADD: begin
        sum_s               = {1'b0, operand_a} + {1'b0, operand_b};
        sc_lo_s             = sum_s[WIDTH-1:0];
        sc_flags_s.carry    = sum_s[WIDTH];
        sc_flags_s.overflow = (operand_a[M] == operand_b[M]) && (sum_s[M] != operand_a[M]);
      end
      OP_SUB: begin
        sum_s               = {1'b0, operand_a} - {1'b0, operand_b};
        sc_lo_s             = sum_s[WIDTH-1:0];
        sc_flags_s.carry    = sum_s[WIDTH];
        sc_flags_s.overflow = (operand_a[M] != operand_b[M]) && (sum_s[M] != operand_a[M]);
      end
      OP_SHL: begin
        sc_lo_s          = {operand_a[M-1:0], 1'b0};
        sc_flags_s.carry = operand_a[M];
      end
      OP_ROL: begin
        sc_lo_s          = {operand_a[M-1:0], operand_a[M]};
        sc_flags_s.carry = operand_a[M];
      end
      OP_SHR: begin
        sc_lo_s          = {1'b0, operand_a[M:1]};
        sc_flags_s.carry = operand_a[0];
      end
      OP_ROR: begin
        sc_lo_s          = {operand_a[0], operand_a[M:1]};
        sc_flags_s.carry = operand_a[0];
      end
      OP_AND: sc_lo_s = operand_a & operand_b;
      OP_OR:  sc_lo_s = operand_a | operand_b;
      OP_XOR: sc_lo_s = operand_a ^ operand_b;
      OP_NOT: sc_lo_s = ~operand_a;
      OP_DIV: begin
        sc_lo_s              = {WIDTH{1'b1}};
        sc_hi_s              = operand_a;
        sc_flags_s.div_zero  = 1'b1;
        sc_flags_s.remainder = (operand_a != {WIDTH{1'b0}});
      end
      OP_MUL: sc_defined_s = 1'b0;
      default: sc_defined_s = 1'b0;
    endcase
    sc_flags_s.zero     = sc_defined_s && (sc_lo_s == {WIDTH{1'b0}});
    sc_flags_s.negative = sc_defined_s && sc_lo_s[M];
  end

  // Flags for a completing MUL/DIV, taken from the final iteration.
  always_comb begin
    it_flags_s           = 6'b0;
    it_flags_s.zero      = (it_lo_s == {WIDTH{1'b0}});
    it_flags_s.negative  = it_lo_s[M];
    if (div_r) begin
      it_flags_s.remainder = (it_hi_s != {WIDTH{1'b0}});
    end else begin
      it_flags_s.carry     = (it_hi_s != {WIDTH{1'b0}});
    end
  end

  // Result/flag registers and the done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      result_r    <= {WIDTH{1'b0}};
      result_hi_r <= {WIDTH{1'b0}};
      flags_r     <= 6'b0;
      done_r      <= 1'b0;
      div_r       <= 1'b0;
    end else begin
      if ((state_r == IDLE) && accept_s && !iter_s) begin
        result_r    <= sc_lo_s;
        result_hi_r <= sc_hi_s;
        flags_r     <= sc_flags_s;
        done_r      <= 1'b1;
      end else if ((state_r == BUSY) && last_s) begin
        result_r    <= it_lo_s;
        result_hi_r <= it_hi_s;
        flags_r     <= it_flags_s;
        done_r      <= 1'b1;
      end else begin
        done_r      <= 1'b0;
      end
      if (load_s) begin
        div_r <= (op == OP_DIV);
      end
    end
  end

  assign ready     = (state_r == IDLE);
  assign done      = done_r;
  assign flags     = flags_r;
  assign result    = out ? result_r : {WIDTH{1'b0}};
  assign result_hi = out ? result_hi_r : {WIDTH{1'b0}};

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=8 and WIDTH=16: directed cases plus
// randomized ops, compared against an arithmetic reference model.
module tb_alu_seq;
  import control::*;

  logic clock;
  logic reset;
  logic out;

  logic        start8, ready8, done8;
  alu_op_e     op8;
  logic [7:0]  a8, b8, res8, hi8;
  alu_flags_t  flags8;

  logic        start16, ready16, done16;
  alu_op_e     op16;
  logic [15:0] a16, b16, res16, hi16;
  alu_flags_t  flags16;

  int checks = 0;
  int failures = 0;
  logic [5:0] last_fl;

  alu_seq #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .ready(ready8), .op(op8),
    .operand_a(a8), .operand_b(b8), .out(out), .result(res8), .result_hi(hi8),
    .flags(flags8), .done(done8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clock(clock), .reset(reset), .start(start16), .ready(ready16), .op(op16),
    .operand_a(a16), .operand_b(b16), .out(out), .result(res16), .result_hi(hi16),
    .flags(flags16), .done(done16)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on wide integers; flags packed {z,c,n,v,r,dz}.
  function automatic void model(input int w, input logic [3:0] opc, input logic [15:0] ai,
                                input logic [15:0] bi, output logic [63:0] lo,
                                output logic [63:0] hi, output logic [5:0] fl, output int lat);
    longint unsigned a, b, mask, msb, s;
    logic z, c, n, v, r, dz, def;
    a = 64'(ai); b = 64'(bi);
    mask = (64'd1 << w) - 64'd1;
    msb = 64'd1 << (w - 1);
    lo = 64'd0; hi = 64'd0; s = 64'd0;
    c = 1'b0; v = 1'b0; r = 1'b0; dz = 1'b0; def = 1'b1; lat = 1;
    case (opc)
      4'd0: begin
        s = a + b; lo = s & mask; c = ((s >> w) & 64'd1) != 64'd0;
        v = ((a ^ lo) & (b ^ lo) & msb) != 64'd0;
      end
      4'd1: begin
        lo = (a - b) & mask; c = a < b;
        v = ((a ^ b) & (a ^ lo) & msb) != 64'd0;
      end
      4'd2: begin lo = (a << 1) & mask; c = (a & msb) != 64'd0; end
      4'd3: begin lo = ((a << 1) | (a >> (w - 1))) & mask; c = (a & msb) != 64'd0; end
      4'd4: begin lo = a >> 1; c = (a & 64'd1) != 64'd0; end
      4'd5: begin lo = (a >> 1) | ((a & 64'd1) << (w - 1)); c = (a & 64'd1) != 64'd0; end
      4'd6: lo = a & b;
      4'd7: lo = a | b;
      4'd8: lo = a ^ b;
      4'd9: lo = ~a & mask;
      4'd10: begin
        s = a * b; lo = s & mask; hi = s >> w; c = hi != 64'd0; lat = w + 1;
      end
      4'd11: begin
        if (b == 64'd0) begin
          lo = mask; hi = a; dz = 1'b1;
        end else begin
          lo = a / b; hi = a % b; lat = w + 1;
        end
        r = hi != 64'd0;
      end
      default: def = 1'b0;
    endcase
    z = def && (lo == 64'd0);
    n = def && ((lo & msb) != 64'd0);
    fl = {z, c, n, v, r, dz};
  endfunction

  task automatic drive(input int w, input logic st, input logic [3:0] opc,
                       input logic [15:0] a, input logic [15:0] b);
    if (w == 8) begin
      start8 = st; op8 = alu_op_e'(opc); a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start16 = st; op16 = alu_op_e'(opc); a16 = a; b16 = b;
    end
  endtask

  function automatic void sample(input int w, output logic rdy, output logic dn,
                                 output logic [15:0] lo, output logic [15:0] hi,
                                 output logic [5:0] fl);
    if (w == 8) begin
      rdy = ready8; dn = done8; lo = 16'(res8); hi = 16'(hi8); fl = flags8;
    end else begin
      rdy = ready16; dn = done16; lo = res16; hi = hi16; fl = flags16;
    end
  endfunction

  // Issue one op at the current negedge and check latency, ready and outputs.
  task automatic run(input int w, input logic [3:0] opc, input logic [15:0] a,
                     input logic [15:0] b, input bit poke);
    logic [63:0] elo, ehi;
    logic [5:0]  efl, fl;
    logic [15:0] lo, hi;
    logic        rdy, dn;
    int          lat, cyc;
    string       t;
    t = $sformatf("w%0d op%0d a=%0h b=%0h", w, opc, a, b);
    model(w, opc, a, b, elo, ehi, efl, lat);
    drive(w, 1'b1, opc, a, b);
    @(negedge clock);
    drive(w, 1'b0, opc, a, b);
    cyc = 1;
    sample(w, rdy, dn, lo, hi, fl);
    while (!dn && cyc < 64) begin
      check({t, " ready_busy"}, 64'(rdy), 64'd0);
      drive(w, poke && (cyc == 3), 4'd0, a, b);
      @(negedge clock);
      cyc++;
      sample(w, rdy, dn, lo, hi, fl);
    end
    drive(w, 1'b0, opc, a, b);
    check({t, " latency"}, 64'(cyc), 64'(lat));
    check({t, " ready_done"}, 64'(rdy), 64'd1);
    check({t, " result"}, 64'(lo), elo);
    check({t, " result_hi"}, 64'(hi), ehi);
    check({t, " flags"}, 64'(fl), 64'(efl));
    last_fl = efl;
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [3:0]  ropc;
    int          w;

    reset = 1'b1; out = 1'b1;
    drive(8, 1'b0, 4'd0, 16'd0, 16'd0);
    drive(16, 1'b0, 4'd0, 16'd0, 16'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset ready8", 64'(ready8), 64'd1);
    check("reset done8", 64'(done8), 64'd0);
    check("reset result8", 64'(res8), 64'd0);
    check("reset hi8", 64'(hi8), 64'd0);
    check("reset flags8", 64'(flags8), 64'd0);
    check("reset ready16", 64'(ready16), 64'd1);
    check("reset flags16", 64'(flags16), 64'd0);

    run(8, 4'd0, 16'hF0, 16'h20, 1'b0);
    run(8, 4'd1, 16'h50, 16'h60, 1'b0);
    run(8, 4'd1, 16'h80, 16'h01, 1'b0);
    @(negedge clock);
    check("done one-cycle pulse", 64'(done8), 64'd0);

    run(8, 4'd10, 16'hFF, 16'hFF, 1'b1);
    run(8, 4'd11, 16'd200, 16'd7, 1'b0);
    run(8, 4'd11, 16'd9, 16'd0, 1'b0);
    run(8, 4'd8, 16'h5A, 16'h0F, 1'b0);

    // Reset during the 4th BUSY cycle of a MUL aborts it with no done pulse.
    drive(8, 1'b1, 4'd10, 16'hFF, 16'hFF);
    @(negedge clock);
    drive(8, 1'b0, 4'd10, 16'hFF, 16'hFF);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort ready", 64'(ready8), 64'd1);
    check("abort result", 64'(res8), 64'd0);
    check("abort result_hi", 64'(hi8), 64'd0);
    check("abort flags", 64'(flags8), 64'd0);
    check("abort done", 64'(done8), 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("abort no late done", 64'(done8), 64'd0);
    end

    run(8, 4'd3, 16'h81, 16'h00, 1'b0);
    out = 1'b0;
    #1;
    check("gated result", 64'(res8), 64'd0);
    check("gated result_hi", 64'(hi8), 64'd0);
    check("gated flags", 64'(flags8), 64'(last_fl));
    out = 1'b1;
    #1;
    check("ungated result", 64'(res8), 64'h03);
    @(negedge clock);

    run(16, 4'd10, 16'hFFFF, 16'hFFFF, 1'b1);
    run(16, 4'd11, 16'd50000, 16'd123, 1'b0);
    run(8, 4'd4, 16'h01, 16'h00, 1'b0);
    run(8, 4'd5, 16'h01, 16'h00, 1'b0);
    run(8, 4'd13, 16'h12, 16'h34, 1'b0);

    for (int i = 0; i < 48; i++) begin
      w = ((i % 4) == 3) ? 16 : 8;
      ropc = 4'($urandom_range(0, 15));
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) rb = 16'd0;
      if (w == 8) begin
        ra[15:8] = 8'd0;
        rb[15:8] = 8'd0;
      end
      run(w, ropc, ra, rb, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
